uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver that recovers bytes from the PC serial line and hands each one to the instruction parser as a one-cycle `rx_done_tick` with `received_byte`. It sits directly upstream of the UART-to-I2C instruction parser and owns the baud-rate tick generator, the input synchronizer and the start/stop bit checking. Frames are 8N1 (one start bit, DATA_BITS data bits LSB first, one stop bit, no parity) at 16× oversampling.

## Interface
- `SYS_FREQ`, 100000000: system clock frequency in Hz.
- `BAUD`, 9600: line baud rate.
- `DATA_BITS`, 8: data bits per frame, range 5–8.
- `DIV`, SYS_FREQ/(16*BAUD) with integer truncation (651 at defaults): clocks per oversample tick. Must be ≥ 2.
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high.
- `rx` in 1: asynchronous serial input. Idles high.
- `rx_done_tick` out 1: one-cycle pulse when a frame with a valid stop bit completes.
- `received_byte` out 8: last good byte, LSB-aligned; upper bits are 0 when DATA_BITS < 8. Held until the next good frame.
- `framing_error` out 1: one-cycle pulse when the stop bit samples low.
- `busy` out 1: high in every state except `idle`.

## Operation
- **Synchronizer.** Two flops; both reset to 1. All logic uses the second-stage output `rx_s`.
- **Tick generator.** Counter 0..DIV-1 runs freely from reset, never stops, and wraps to 0. `s_tick` is high for the cycle in which the counter equals DIV-1.
- **Registers.** Oversample counter `s` (4 bits), bit counter `n` (3 bits), shift register `b` (DATA_BITS).
- **States.** `idle`, `start`, `data`, `stop`, `brk`.
  - **idle:** when `rx_s`==0, go to `start` with s=0. This needs no `s_tick`.
  - **start:** on each `s_tick`, s++. At the tick where s==7 (mid start bit):
    - if `rx_s`==0, go to `data` with s=0, n=0;
    - else it is a glitch: return to `idle` with no output.
  - **data:** on each `s_tick`, s++. At the tick where s==15:
    - s=0, b={rx_s, b[DATA_BITS-1:1]};
    - if n==DATA_BITS-1, go to `stop`; else n++.
  - **stop:** on each `s_tick`, s++. At the tick where s==15:
    - if `rx_s`==1, go to `idle`, pulse `rx_done_tick` and load `received_byte`=b;
    - else pulse `framing_error`, leave `received_byte` unchanged and go to `brk`.
  - **brk:** wait for `rx_s`==1, then go to `idle`. This prevents a held-low line (break) from retriggering frames.
- A stop-bit pass and a start-bit detection never coincide: `idle` is always entered for at least one cycle. A back-to-back next start bit is therefore caught on the following cycle.
- **Reset.** Synchronous reset at any point, including mid-frame:
  - state=`idle`, s=n=0, b=0, tick counter=0, sync flops=1;
  - `rx_done_tick`=0, `framing_error`=0, `busy`=0, `received_byte`=0.
  - A partial frame is discarded. No spurious pulse may follow release of reset.

## Timing
- `rx_done_tick` and `framing_error` are registered pulses of exactly one `clk` cycle, asserted the cycle after the stop-sample `s_tick`. `received_byte` is valid in the same cycle as `rx_done_tick`.
- Pulse spacing is ≥ 16·(DATA_BITS+1.5)·DIV clocks. The downstream parser needs no backpressure, and none is provided.
- **Detection latency.** A falling edge on `rx` reaches `start` after 2–3 clocks (synchronizer). The start bit is confirmed at the 8th `s_tick` after that.
- **Sampling points.** Each data bit and the stop bit are sampled 16 ticks apart, at mid-bit ±1 tick, due to tick phase.
- **Clock tolerance.** Combined clock/baud error up to ±3% must still decode.
- **Pulse exclusivity.** `rx_done_tick` and `framing_error` are never high together.

## Test plan
Bench parameters: SYS_FREQ=1600000, BAUD=10000, so DIV=10 and one bit = 160 clk.
1. Send frame 0xFF, then after 2 idle bit-times send 0xA5 → exactly two `rx_done_tick` pulses with `received_byte`=0xFF then 0xA5; `busy` drops between frames; no `framing_error`.
2. Drive `rx` low for 40 clk, then high → no `rx_done_tick`, no `framing_error`; `busy` high then low; `received_byte` unchanged.
3. Send 0x3C with stop bit driven 0, then hold `rx` low 1000 clk, then release and send 0x48 → one `framing_error` pulse, no `rx_done_tick` during the break, `received_byte` stays at the previous value; then `rx_done_tick` with 0x48.
4. Send 0xFF, 0x48, 0x01, 0xFF back-to-back with zero idle gap → four `rx_done_tick` pulses in order, each carrying the correct byte; this is the parser's start/addr/op/stop sequence.
5. Assert `reset` for 1 cycle midway through the data bits of 0x55, then send 0x81 cleanly → no pulse from the aborted frame; `received_byte` reads 0x00 after reset, then 0x81 with one `rx_done_tick`.
6. Send 0x96 with the line baud skewed +3% and −3% → `received_byte`=0x96 in both cases, no `framing_error`.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling 8N1 serial receiver with input synchronizer,
// free-running oversample tick generator, start-glitch rejection,
// stop-bit checking and break (held-low line) handling.
module uart_rx #(
  parameter int SYS_FREQ  = 100000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int DIV       = SYS_FREQ / (16 * BAUD)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_done_tick,
  output logic [7:0] received_byte,
  output logic       framing_error,
  output logic       busy
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [2:0]    N_LAST   = 3'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BRK   = 3'd4;

  logic [1:0]           sync_q, sync_d;
  logic [CW-1:0]        tick_q, tick_d;
  logic [2:0]           state_q, state_d;
  logic [3:0]           s_q, s_d;
  logic [2:0]           n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic [7:0]           byte_q, byte_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;
  logic                 s_tick;

  assign rx_s   = sync_q[1];
  assign s_tick = (tick_q == DIV_LAST);

  // Two-stage synchronizer shifting the raw line in; the older stage is rx_s.
  always_comb begin
    sync_d = {sync_q[0], rx};
  end

  // Oversample tick counter: free-running 0..DIV-1, never paused by the FSM.
  always_comb begin
    tick_d = s_tick ? '0 : tick_q + 1'b1;
  end

  // Frame FSM: confirm start at mid-bit, sample data/stop every 16 ticks.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = 4'd0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == 4'd7) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = 4'd0;
              n_d     = 3'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d = 4'd0;
            b_d = {rx_s, b_q[DATA_BITS-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d = 4'd0;
            if (rx_s) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              byte_d  = 8'(b_q);
            end else begin
              state_d = ST_BRK;
              ferr_d  = 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_BRK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register bank with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      tick_q  <= '0;
      state_q <= ST_IDLE;
      s_q     <= 4'd0;
      n_q     <= 3'd0;
      b_q     <= '0;
      byte_q  <= 8'd0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_done_tick  = done_q;
  assign framing_error = ferr_q;
  assign received_byte = byte_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at DIV=10 (one bit = 160 clk).
// A line-level model produces the expected bytes and error counts.
module tb_uart_rx;

  localparam int BIT = 160;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rx_done_tick;
  logic [7:0] received_byte;
  logic       framing_error;
  logic       busy;

  int n_cmp;
  int n_err;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         ferr_count;
  int         both_count;
  logic [7:0] last_good;

  uart_rx #(
    .SYS_FREQ (1600000),
    .BAUD     (10000),
    .DATA_BITS(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_done_tick (rx_done_tick),
    .received_byte(received_byte),
    .framing_error(framing_error),
    .busy         (busy)
  );

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse monitor: logs every good byte and framing error seen on the outputs.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) got_q.push_back(received_byte);
    if (framing_error === 1'b1) ferr_count++;
    if (rx_done_tick === 1'b1 && framing_error === 1'b1) both_count++;
  end

  task automatic idle_clks(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame; the model records the byte only if the stop bit is high.
  task automatic send_frame(input logic [7:0] data, input logic stop_val, input int bit_clks);
    rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx = stop_val;
    repeat (bit_clks) @(negedge clk);
    if (stop_val) begin
      exp_q.push_back(data);
      last_good = data;
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    ferr_count = 0;
  endtask

  task automatic check_bytes(input string name);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("[TB] FAIL %s count: got %0d pulses, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("[TB] FAIL %s byte %0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_ferr(input string name, input int expected);
    n_cmp++;
    if (ferr_count !== expected) begin
      n_err++;
      $display("[TB] FAIL %s framing_error: got %0d pulses expected %0d", name, ferr_count, expected);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rx_done_tick, framing_error, busy, received_byte} !== 11'd0) begin
      n_err++;
      $display("[TB] FAIL reset_state: got done=%b ferr=%b busy=%b byte=%h expected all 0",
               rx_done_tick, framing_error, busy, received_byte);
    end
    reset = 1'b0;
    last_good = 8'h00;
    idle_clks(50);
    clear_logs();
  endtask

  task automatic test_two_frames();
    clear_logs();
    send_frame(8'hFF, 1'b1, BIT);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL two_frames busy_between: got %b expected 0", busy);
    end
    idle_clks(2 * BIT);
    send_frame(8'hA5, 1'b1, BIT);
    idle_clks(2 * BIT);
    check_bytes("two_frames");
    check_ferr("two_frames", 0);
  endtask

  task automatic test_glitch();
    clear_logs();
    rx = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL glitch busy_high: got %b expected 1", busy);
    end
    idle_clks(120);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL glitch busy_low: got %b expected 0", busy);
    end
    check_bytes("glitch");
    check_ferr("glitch", 0);
    n_cmp++;
    if (received_byte !== last_good) begin
      n_err++;
      $display("[TB] FAIL glitch held_byte: got %h expected %h", received_byte, last_good);
    end
  endtask

  task automatic test_framing_break();
    clear_logs();
    send_frame(8'h3C, 1'b0, BIT);
    repeat (1000) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL break busy_in_break: got %b expected 1", busy);
    end
    idle_clks(BIT);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL break busy_after_release: got %b expected 0", busy);
    end
    check_bytes("break_no_done");
    check_ferr("break", 1);
    n_cmp++;
    if (received_byte !== last_good) begin
      n_err++;
      $display("[TB] FAIL break held_byte: got %h expected %h", received_byte, last_good);
    end
    send_frame(8'h48, 1'b1, BIT);
    idle_clks(2 * BIT);
    check_bytes("break_recover");
    check_ferr("break_recover", 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    seq = '{8'hFF, 8'h48, 8'h01, 8'hFF};
    clear_logs();
    for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b1, BIT);
    idle_clks(2 * BIT);
    check_bytes("back_to_back");
    check_ferr("back_to_back", 0);
  endtask

  task automatic test_random();
    int exp_ferr;
    clear_logs();
    exp_ferr = 0;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      logic       good;
      d    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_frame(d, good, $urandom_range(156, 164));
      if (!good) begin
        exp_ferr++;
        repeat ($urandom_range(0, 300)) @(negedge clk);
        idle_clks(20);
      end
      idle_clks($urandom_range(0, 300));
    end
    idle_clks(2 * BIT);
    check_bytes("random");
    check_ferr("random", exp_ferr);
    n_cmp++;
    if (received_byte !== last_good) begin
      n_err++;
      $display("[TB] FAIL random last_byte: got %h expected %h", received_byte, last_good);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h55;
    clear_logs();
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = d[3];
    repeat (BIT / 2) @(negedge clk);
    rx    = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_good = 8'h00;
    n_cmp++;
    if (received_byte !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midreset state: got byte=%h busy=%b expected byte=00 busy=0", received_byte, busy);
    end
    idle_clks(3 * BIT);
    check_bytes("midreset_no_pulse");
    check_ferr("midreset", 0);
    send_frame(8'h81, 1'b1, BIT);
    idle_clks(2 * BIT);
    check_bytes("midreset_recover");
  endtask

  task automatic test_baud_skew();
    clear_logs();
    send_frame(8'h96, 1'b1, 165);
    idle_clks(2 * BIT);
    send_frame(8'h96, 1'b1, 155);
    idle_clks(2 * BIT);
    check_bytes("baud_skew");
    check_ferr("baud_skew", 0);
  endtask

  task automatic test_exclusive();
    n_cmp++;
    if (both_count !== 0) begin
      n_err++;
      $display("[TB] FAIL exclusive: got %0d overlapping cycles expected 0", both_count);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    n_cmp      = 0;
    n_err      = 0;
    ferr_count = 0;
    both_count = 0;
    rx         = 1'b1;
    reset      = 1'b1;
    last_good  = 8'h00;
    test_reset();
    test_two_frames();
    test_glitch();
    test_framing_break();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_baud_skew();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
